cache_mem_responder: RTL and testbench

- Memory-side responder for one cache line's memory port; the opposite end of the line's mem_rdreq/mem_wrreq/mem_out_valid protocol.
- Buffers line requests (one per cycle, burst fill/flush) in an in-order FIFO and issues them to a backing bus with a req/gnt handshake.
- Returns read data in order and drives the line's pause input when its buffer nears capacity.

---
 rtl/cache_mem_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side end of a cache line's rdreq/wrreq/out_valid
// port. Requests are queued in program order, issued to a req/gnt backing bus,
// and read data is returned in order one cycle after bus_rvalid.
module cache_mem_responder #(
  parameter int ADDRBITS     = 32,
  parameter int DATABITS     = 32,
  parameter int FIFOBITS     = 3,
  parameter int PAUSE_MARGIN = 2,
  parameter int MAXOUTBITS   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] mem_addr,
  input  logic [DATABITS-1:0] mem_in,
  input  logic                mem_wrreq,
  input  logic                mem_rdreq,
  output logic [DATABITS-1:0] mem_out,
  output logic                mem_out_valid,
  output logic                mem_pause,
  output logic [ADDRBITS-1:0] bus_addr,
  output logic [DATABITS-1:0] bus_wdata,
  output logic                bus_we,
  output logic                bus_req,
  input  logic                bus_gnt,
  input  logic [DATABITS-1:0] bus_rdata,
  input  logic                bus_rvalid,
  output logic                err
);

  localparam int DEPTH = 1 << FIFOBITS;
  localparam int CNTW  = FIFOBITS + 1;
  localparam logic [MAXOUTBITS-1:0] MAXOUT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Request FIFO storage (no reset needed; validity tracked by count)
  logic [ADDRBITS-1:0] fifo_addr_q [DEPTH];
  logic [DATABITS-1:0] fifo_data_q [DEPTH];
  logic                fifo_we_q   [DEPTH];

  state_t              state_q, state_d;
  logic [FIFOBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFOBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [MAXOUTBITS-1:0] outst_q, outst_d;
  logic                fresh_q, fresh_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDRBITS-1:0] bus_addr_q, bus_addr_d;
  logic [DATABITS-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATABITS-1:0] mem_out_q, mem_out_d;
  logic                mem_out_valid_q, mem_out_valid_d;
  logic                mem_pause_q, mem_pause_d;
  logic                err_q, err_d;

  logic                push_req;
  logic [DATABITS-1:0] push_data;
  logic                fifo_empty;
  logic                cand_valid;
  logic [ADDRBITS-1:0] cand_addr;
  logic [DATABITS-1:0] cand_data;
  logic                cand_we;
  logic                cand_issuable;
  logic                take;
  logic                pop;
  logic                bypass;
  logic                fifo_wr;
  logic                overflow;
  logic                gnt_fire;
  logic                rd_grant;
  logic                rv_accept;
  logic                rv_spurious;

  assign push_req    = mem_wrreq | mem_rdreq;
  assign push_data   = mem_wrreq ? mem_in : '0;
  assign fifo_empty  = (count_q == '0);
  assign gnt_fire    = (state_q == REQ) && bus_gnt;
  assign rd_grant    = gnt_fire && !bus_we_q;
  assign rv_accept   = bus_rvalid && (outst_q != '0);
  assign rv_spurious = bus_rvalid && (outst_q == '0);

  // The next request to issue is the FIFO head, or the incoming push when the
  // FIFO is empty; issuing it straight from the input keeps push-to-req at one
  // cycle without reordering anything.
  always_comb begin
    if (!fifo_empty) begin
      cand_valid = 1'b1;
      cand_addr  = fifo_addr_q[rd_ptr_q];
      cand_data  = fifo_data_q[rd_ptr_q];
      cand_we    = fifo_we_q[rd_ptr_q];
    end else begin
      cand_valid = push_req;
      cand_addr  = mem_addr;
      cand_data  = push_data;
      cand_we    = mem_wrreq;
    end
  end

  // Outstanding-read count after this cycle's grant and return
  always_comb begin
    outst_d = outst_q;
    if (rd_grant && !rv_accept) begin
      outst_d = outst_q + 1'b1;
    end else if (!rd_grant && rv_accept) begin
      outst_d = outst_q - 1'b1;
    end
  end

  assign cand_issuable = cand_valid && (cand_we || (outst_d != MAXOUT));

  // Issue FSM: next state, bus request registers and candidate consumption
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    take        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_issuable) begin
          take      = 1'b1;
          bus_req_d = 1'b1;
          state_d   = REQ;
        end else begin
          bus_req_d = 1'b0;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (cand_issuable) begin
            take = 1'b1;
          end else begin
            bus_req_d = 1'b0;
            // A pending but non-issuable candidate is always a read blocked
            // on the outstanding limit.
            state_d   = cand_valid ? WAIT : IDLE;
          end
        end
      end
      WAIT: begin
        if (outst_d != MAXOUT) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
    if (take) begin
      bus_addr_d  = cand_addr;
      bus_wdata_d = cand_data;
      bus_we_d    = cand_we;
    end
  end

  assign pop      = take && !fifo_empty;
  assign bypass   = take && fifo_empty;
  assign fifo_wr  = push_req && !bypass && ((count_q != CNTW'(DEPTH)) || pop);
  assign overflow = push_req && !bypass && (count_q == CNTW'(DEPTH)) && !pop;

  // FIFO pointers, occupancy and the registered pause/return/error outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    mem_pause_d     = ((DEPTH - int'(count_d)) <= PAUSE_MARGIN);
    mem_out_valid_d = rv_accept;
    mem_out_d       = rv_accept ? bus_rdata : mem_out_q;
    // Until a read has been granted after reset, an unmatched return can only
    // be a stale response to a request that reset discarded, so it is dropped
    // without flagging.
    fresh_d         = fresh_q && !rd_grant;
    err_d           = err_q | (mem_wrreq & mem_rdreq) | overflow
                    | (rv_spurious & !fresh_q);
  end

  // Request FIFO write port
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_we_q[wr_ptr_q]   <= mem_wrreq;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      outst_q         <= '0;
      fresh_q         <= 1'b1;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      mem_out_q       <= '0;
      mem_out_valid_q <= 1'b0;
      mem_pause_q     <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      outst_q         <= outst_d;
      fresh_q         <= fresh_d;
      bus_req_q       <= bus_req_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      mem_out_q       <= mem_out_d;
      mem_out_valid_q <= mem_out_valid_d;
      mem_pause_q     <= mem_pause_d;
      err_q           <= err_d;
    end
  end

  assign mem_out       = mem_out_q;
  assign mem_out_valid = mem_out_valid_q;
  assign mem_pause     = mem_pause_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_we        = bus_we_q;
  assign bus_req       = bus_req_q;
  assign err           = err_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed testbench for cache_mem_responder with a behavioural backing-bus
// memory (programmable grant and read latency) and a read-return monitor.
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_in = '0;
  logic        mem_wrreq = 1'b0;
  logic        mem_rdreq = 1'b0;
  logic [31:0] mem_out;
  logic        mem_out_valid;
  logic        mem_pause;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_rvalid = 1'b0;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(
    .ADDRBITS(32), .DATABITS(32), .FIFOBITS(3), .PAUSE_MARGIN(2), .MAXOUTBITS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq),
    .mem_out(mem_out), .mem_out_valid(mem_out_valid), .mem_pause(mem_pause),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .err(err)
  );

  // Backing bus model state
  logic [31:0] bmem [0:1023];
  logic        gnt_en = 1'b0;
  int          rd_lat = 2;
  int          cyc = 0;
  int          inj_req = 0;
  int          inj_served = 0;
  int          m_out = 0;
  int          m_out_max = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  int          ret_due[$];
  logic [31:0] ret_data[$];
  logic [31:0] rx[$];

  function automatic logic [31:0] pre(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Bus model: decides grant/return for the upcoming rising edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    bus_gnt = gnt_en;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    if (ret_due.size() != 0 && ret_due[0] == cyc) begin
      bus_rvalid = 1'b1;
      bus_rdata = ret_data.pop_front();
      void'(ret_due.pop_front());
      m_out = m_out - 1;
    end else if (inj_served != inj_req) begin
      bus_rvalid = 1'b1;
      bus_rdata = 32'hBAD0BAD0;
      inj_served = inj_served + 1;
    end
    if (bus_req && bus_gnt) begin
      log_addr.push_back(bus_addr);
      log_data.push_back(bus_wdata);
      log_we.push_back(bus_we);
      if (bus_we) begin
        bmem[bus_addr[11:2]] = bus_wdata;
      end else begin
        ret_due.push_back(cyc + rd_lat);
        ret_data.push_back(bmem[bus_addr[11:2]]);
        m_out = m_out + 1;
        if (m_out > m_out_max) m_out_max = m_out;
      end
    end
  end

  // Read-return monitor
  always @(negedge clk) begin
    if (mem_out_valid) rx.push_back(mem_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    mem_wrreq = wr;
    mem_rdreq = rd;
    mem_addr = a;
    mem_in = d;
    step();
    mem_wrreq = 1'b0;
    mem_rdreq = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_we.delete();
    rx.delete();
  endtask

  initial begin
    logic [31:0] exp_v [0:4];
    int sent;
    for (int i = 0; i < 1024; i++) bmem[i] = pre(32'(i * 4));
    bmem[64] = 32'hDEADBEEF;

    // Reset state
    reset_n = 1'b0;
    step();
    step();
    chk("rst_mem_out", mem_out, 32'h0);
    chk("rst_mem_out_valid", {31'b0, mem_out_valid}, 32'h0);
    chk("rst_mem_pause", {31'b0, mem_pause}, 32'h0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    reset_n = 1'b1;
    step();

    // 1: single read, immediate grant, rvalid two cycles after grant
    clear_logs();
    gnt_en = 1'b1;
    rd_lat = 2;
    push(1'b0, 1'b1, 32'h100, 32'h0);
    chk("t1_bus_req", {31'b0, bus_req}, 32'h1);
    chk("t1_bus_addr", bus_addr, 32'h100);
    chk("t1_bus_we", {31'b0, bus_we}, 32'h0);
    exp_v[0] = 0; exp_v[1] = 0; exp_v[2] = 0; exp_v[3] = 1; exp_v[4] = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      chk($sformatf("t1_valid_t%0d", k + 1), {31'b0, mem_out_valid}, exp_v[k]);
      if (k == 1) chk("t1_req_dropped", {31'b0, bus_req}, 32'h0);
      if (k == 3) chk("t1_mem_out", mem_out, 32'hDEADBEEF);
    end
    chk("t1_err", {31'b0, err}, 32'h0);

    // 2: flush burst of 31 writes, grant withheld for the first 5 cycles
    clear_logs();
    gnt_en = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (i == 5) gnt_en = 1'b1;
      push(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'(i));
    end
    for (int b = 0; b < 100 && log_addr.size() < 31; b++) step();
    chk("t2_write_count", 32'(log_addr.size()), 32'd31);
    for (int i = 0; i < 31 && i < log_addr.size(); i++) begin
      chk($sformatf("t2_addr_%0d", i), log_addr[i], 32'h200 + 32'(i * 4));
      chk($sformatf("t2_data_%0d", i), log_data[i], 32'(i));
      chk($sformatf("t2_we_%0d", i), {31'b0, log_we[i]}, 32'h1);
    end
    chk("t2_err", {31'b0, err}, 32'h0);

    // 2b: pause ramp with grant held low; writes are never refused up to DEPTH
    clear_logs();
    gnt_en = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      push(1'b1, 1'b0, 32'h280 + 32'(k * 4), 32'h1000 + 32'(k));
      chk($sformatf("t2b_pause_%0d", k), {31'b0, mem_pause}, (k - 1 >= 6) ? 32'h1 : 32'h0);
    end
    chk("t2b_err_full", {31'b0, err}, 32'h0);
    gnt_en = 1'b1;
    for (int b = 0; b < 50 && log_addr.size() < 9; b++) step();
    step();
    chk("t2b_write_count", 32'(log_addr.size()), 32'd9);
    if (log_addr.size() == 9) chk("t2b_last_addr", log_addr[8], 32'h2A4);
    chk("t2b_pause_drained", {31'b0, mem_pause}, 32'h0);

    // 3: fill of 32 reads under pause, 4-cycle read latency
    clear_logs();
    rd_lat = 4;
    gnt_en = 1'b1;
    m_out = 0;
    m_out_max = 0;
    sent = 0;
    for (int b = 0; b < 2000 && (sent < 32 || rx.size() < 32); b++) begin
      if (sent < 32 && !mem_pause) begin
        mem_rdreq = 1'b1;
        mem_addr = 32'h300 + 32'(sent * 4);
        sent++;
      end
      step();
      mem_rdreq = 1'b0;
    end
    chk("t3_return_count", 32'(rx.size()), 32'd32);
    chk("t3_max_outstanding", 32'(m_out_max), 32'd3);
    for (int i = 0; i < 32 && i < rx.size(); i++) begin
      chk($sformatf("t3_data_%0d", i), rx[i], pre(32'h300 + 32'(i * 4)));
    end
    chk("t3_err", {31'b0, err}, 32'h0);

    // 4: write then read of the same address
    clear_logs();
    rd_lat = 2;
    push(1'b1, 1'b0, 32'h40, 32'h55);
    push(1'b0, 1'b1, 32'h40, 32'h0);
    for (int b = 0; b < 50 && rx.size() < 1; b++) step();
    chk("t4_return_count", 32'(rx.size()), 32'd1);
    if (rx.size() >= 1) chk("t4_mem_out", rx[0], 32'h55);
    if (log_we.size() >= 2) begin
      chk("t4_first_is_write", {31'b0, log_we[0]}, 32'h1);
      chk("t4_second_is_read", {31'b0, log_we[1]}, 32'h0);
      chk("t4_read_addr", log_addr[1], 32'h40);
    end else begin
      chk("t4_bus_count", 32'(log_we.size()), 32'd2);
    end

    // 5a: simultaneous write and read request
    do_reset();
    clear_logs();
    chk("t5a_err_before", {31'b0, err}, 32'h0);
    push(1'b1, 1'b1, 32'h500, 32'hABCD);
    chk("t5a_err_set", {31'b0, err}, 32'h1);
    for (int b = 0; b < 10; b++) step();
    chk("t5a_bus_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      chk("t5a_write_addr", log_addr[0], 32'h500);
      chk("t5a_write_data", log_data[0], 32'hABCD);
      chk("t5a_write_we", {31'b0, log_we[0]}, 32'h1);
    end
    chk("t5a_err_sticky", {31'b0, err}, 32'h1);

    // 5b: push into a full FIFO while grant is low
    do_reset();
    clear_logs();
    gnt_en = 1'b0;
    for (int k = 0; k < 9; k++) push(1'b1, 1'b0, 32'h600 + 32'(k * 4), 32'(k));
    chk("t5b_err_at_full", {31'b0, err}, 32'h0);
    push(1'b1, 1'b0, 32'h700, 32'h77);
    chk("t5b_err_overflow", {31'b0, err}, 32'h1);
    gnt_en = 1'b1;
    for (int b = 0; b < 30; b++) step();
    chk("t5b_bus_count", 32'(log_addr.size()), 32'd9);
    if (log_addr.size() >= 9) chk("t5b_last_addr", log_addr[8], 32'h620);

    // 5c: bus_rvalid with nothing outstanding
    do_reset();
    clear_logs();
    rd_lat = 2;
    push(1'b0, 1'b1, 32'h100, 32'h0);
    for (int b = 0; b < 20 && rx.size() < 1; b++) step();
    chk("t5c_err_before", {31'b0, err}, 32'h0);
    inj_req++;
    step();
    step();
    step();
    chk("t5c_err_spurious", {31'b0, err}, 32'h1);
    chk("t5c_no_extra_return", 32'(rx.size()), 32'd1);

    // 6: asynchronous reset with 4 queued and 2 outstanding
    do_reset();
    clear_logs();
    gnt_en = 1'b1;
    rd_lat = 20;
    m_out = 0;
    push(1'b0, 1'b1, 32'h100, 32'h0);
    push(1'b0, 1'b1, 32'h104, 32'h0);
    step();
    gnt_en = 1'b0;
    chk("t6_outstanding", 32'(m_out), 32'd2);
    push(1'b0, 1'b1, 32'h200, 32'h0);
    push(1'b0, 1'b1, 32'h204, 32'h0);
    push(1'b0, 1'b1, 32'h208, 32'h0);
    push(1'b0, 1'b1, 32'h20C, 32'h0);
    push(1'b1, 1'b1, 32'h300, 32'h99);
    chk("t6_pre_req", {31'b0, bus_req}, 32'h1);
    chk("t6_pre_addr", bus_addr, 32'h200);
    chk("t6_pre_err", {31'b0, err}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_bus_req", {31'b0, bus_req}, 32'h0);
    chk("t6_async_bus_addr", bus_addr, 32'h0);
    chk("t6_async_bus_we", {31'b0, bus_we}, 32'h0);
    chk("t6_async_bus_wdata", bus_wdata, 32'h0);
    chk("t6_async_mem_out", mem_out, 32'h0);
    chk("t6_async_valid", {31'b0, mem_out_valid}, 32'h0);
    chk("t6_async_pause", {31'b0, mem_pause}, 32'h0);
    chk("t6_async_err", {31'b0, err}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    gnt_en = 1'b1;
    for (int b = 0; b < 30; b++) step();
    chk("t6_stale_no_valid", 32'(rx.size()), 32'd0);
    chk("t6_stale_no_err", {31'b0, err}, 32'h0);
    chk("t6_no_reissue", 32'(log_addr.size()), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
